// File: rtl/mul_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mul_seq_ctrl_pkg
//   Shared constants for the iterative multiply sequencer.
//   - FSM state encodings (IDLE / RUN / DONE)
//   - Adder mode select values for the external shared adder/subtractor
// ---------------------------------------------------------------------------
package mul_seq_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic ADD_OP_ADD = 1'b0;
    localparam logic ADD_OP_SUB = 1'b1;

endpackage : mul_seq_ctrl_pkg

// File: rtl/mul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mul_seq_ctrl
//   Shift-and-add multiply sequencer. Performs one pass per clock through an
//   external, shared WIDTH-bit ripple adder/subtractor and builds a 2*WIDTH
//   bit signed or unsigned product.
//
// Ports
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   start_valid/ready     : operation request handshake (ready only in IDLE)
//   op_signed, op_a, op_b : operation, sampled on accept
//   res_valid/ready       : result handshake; result held until taken
//   res_hi, res_lo        : product high / low halves
//   busy                  : high in RUN or DONE
//   add_a, add_b          : adder operands (partial product high half, mcand/0)
//   add_cin, add_sel      : adder carry-in and mode (0 add, 1 subtract)
//   add_s, add_cout, add_of : adder sum, carry-out, signed overflow
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Valid, once raised by this block, stays high with stable data
// until the matching ready is seen.
// ---------------------------------------------------------------------------
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             busy,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    output logic             add_sel,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout,
    input  logic             add_of
);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_p_hi;
    logic [WIDTH-1:0] r_p_lo;
    logic             r_sgn;
    logic [CNT_W-1:0] r_cnt;

    logic w_last;
    logic w_ext;
    logic w_sub;

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // Signed: the true sign of the sum is the sum MSB corrected by overflow.
    // Unsigned: the carry-out is the extra sum bit.
    assign w_ext = r_sgn ? (add_s[WIDTH-1] ^ add_of) : add_cout;

    // In signed mode the multiplier MSB has negative weight, so the final
    // partial product is subtracted rather than added.
    assign w_sub = r_sgn && r_p_lo[0] && w_last;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start_valid) w_next_state = ST_RUN;
            ST_RUN:  if (w_last)      w_next_state = ST_DONE;
            ST_DONE: if (res_ready)   w_next_state = ST_IDLE;
            default:                  w_next_state = ST_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        start_ready = (r_state == ST_IDLE);
        busy        = (r_state == ST_RUN) || (r_state == ST_DONE);
        res_valid   = (r_state == ST_DONE);
        res_hi      = r_p_hi;
        res_lo      = r_p_lo;
        add_a       = '0;
        add_b       = '0;
        add_sel     = ADD_OP_ADD;
        add_cin     = 1'b0;
        if (r_state == ST_RUN) begin
            add_a   = r_p_hi;
            add_b   = r_p_lo[0] ? r_mcand : '0;
            add_sel = w_sub ? ADD_OP_SUB : ADD_OP_ADD;
            add_cin = w_sub;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand <= '0;
            r_p_hi  <= '0;
            r_p_lo  <= '0;
            r_sgn   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_valid) begin
                        r_mcand <= op_a;
                        r_p_lo  <= op_b;
                        r_p_hi  <= '0;
                        r_sgn   <= op_signed;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    // Sum lands in the high half, shifted right by one with
                    // the extension bit on top; consumed multiplier bits
                    // fall out of the bottom of p_lo.
                    {r_p_hi, r_p_lo} <= {w_ext, add_s, r_p_lo[WIDTH-1:1]};
                    r_cnt            <= r_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule : mul_seq_ctrl

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Iterative shift-and-add multiply sequencer for the pipelined CPU's multi-cycle MUL path.
- Owns no adder. It drives the operand, carry-in and add/sub select lines of one shared WIDTH-bit ripple adder/subtractor for one pass per clock.
- It consumes the adder's sum, carry-out and overflow, and produces a 2*WIDTH-bit signed or unsigned product.
- Accepts one operation at a time over a valid/ready handshake and holds the result until it is taken.

Parameters:
- WIDTH, 32: operand width. The product is 2*WIDTH bits.
- CNT_W, 5: iteration counter width. Must satisfy 2**CNT_W >= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start_valid  input  1  new operation offered.
- start_ready  output  1  block can accept an operation; high only in IDLE.
- op_signed  input  1  1 = two's-complement multiply, 0 = unsigned; sampled on accept.
- op_a  input  WIDTH  multiplicand; sampled on accept.
- op_b  input  WIDTH  multiplier; sampled on accept.
- res_valid  output  1  product available.
- res_ready  input  1  consumer takes the product.
- res_hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH].
- res_lo  output  WIDTH  product bits [WIDTH-1:0].
- busy  output  1  high in RUN or DONE.
- add_a  output  WIDTH  adder operand A (running partial product, high half).
- add_b  output  WIDTH  adder operand B (multiplicand or zero).
- add_cin  output  1  adder carry-in; always equal to add_sel.
- add_sel  output  1  adder mode: 0 = add, 1 = subtract (adder inverts B internally).
- add_s  input  WIDTH  adder sum, combinational from add_a/add_b.
- add_cout  input  1  adder carry-out.
- add_of  input  1  adder signed overflow.

Behaviour:
- **States.** IDLE, RUN, DONE, with registers mcand, p_hi, p_lo, sgn and cnt.
- **Reset** (synchronous, wins over everything, including mid-RUN):
  - state goes to IDLE; cnt, p_hi, p_lo, mcand and sgn go to 0.
  - Outputs: res_valid=0, busy=0, start_ready=1, res_hi=res_lo=0.
  - Adder drive lines go to 0. Any in-flight operation is discarded with no result.
- **IDLE.**
  - On start_valid && start_ready: mcand<=op_a, p_lo<=op_b, p_hi<=0, sgn<=op_signed, cnt<=0, state<=RUN.
  - start_valid is ignored in every other state (start_ready=0).
- **RUN, one adder pass per cycle.**
  - Drive add_a=p_hi and add_b = p_lo[0] ? mcand : 0.
  - Drive add_sel = add_cin = sgn && p_lo[0] && (cnt==WIDTH-1). In signed mode the last partial product is subtracted.
  - Shift-in bit: unsigned gives ext=add_cout; signed gives ext=add_s[WIDTH-1]^add_of.
  - Register update: {p_hi,p_lo} <= {ext, add_s, p_lo[WIDTH-1:1]}; cnt<=cnt+1.
  - When cnt==WIDTH-1 the update occurs and state<=DONE.
  - Clock period must cover full adder settle time; the block adds no wait states.
- **Outside RUN**, add_a, add_b, add_sel and add_cin are driven to 0.
- **DONE.**
  - res_valid=1, res_hi=p_hi, res_lo=p_lo, held stable while res_ready=0.
  - On res_ready: state<=IDLE.
  - res_hi/res_lo keep the last product until the next accept. res_valid drops.
- **Latency.** The accept edge is cycle 0. res_valid rises after exactly WIDTH further edges (cycle WIDTH). Minimum issue interval is WIDTH+2 cycles.
- **Zero operands** still take the full WIDTH passes; there is no early termination.
- **Simultaneous res_ready and start_valid in DONE:** only the retire happens. The new operation is accepted in the following IDLE cycle.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - ADD_OP_ADD=1'b0 and ADD_OP_SUB=1'b1 for the adder select.
- No sub-module inside mul_seq_ctrl; the adder stays external and shared.
- Bench and top level pair it with the team's 32-bit adder/subtractor with carry-in (adder32bitcin).

Test Plan:
1. Unsigned 3 x 5, res_ready=1 → res_valid exactly 32 cycles after accept; res_hi=0x00000000, res_lo=0x0000000F; add_sel never 1.
2. Unsigned 0xFFFFFFFF x 0xFFFFFFFF → res_hi=0xFFFFFFFE, res_lo=0x00000001.
3. Signed -3 (0xFFFFFFFD) x 5 → {res_hi,res_lo}=0xFFFFFFFF_FFFFFFF1. Signed 0x80000000 x 0x80000000 → 0x40000000_00000000 (exercises add_sel=1 with add_of=1 on the last pass).
4. Backpressure: hold res_ready=0 for 10 cycles in DONE, with start_valid=1 throughout → res_valid and result stable, start_ready=0, no second accept. Release → IDLE, then accept on the next cycle.
5. Assert reset at cnt==17 of an unsigned 7 x 9 → next cycle IDLE, busy=0, res_valid=0, adder lines 0. A fresh 2 x 4 then yields 0x00000008 with normal latency.
